// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU responder.
//   - Opcode encodings accepted on req_op.
//   - FSM state encoding (IDLE / CALC / RESP).
//   - Helpers that classify opcodes for the datapath.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Ops that go through the sliced adder.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops that compute a - b, i.e. add ~b with a carry seed of 1.
    function automatic logic is_subtract(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_chunk_adder.sv
// CHUNK-bit ripple adder slice used once per cycle by the responder.
// Ports:
//   a, b  in   CHUNK-bit addends
//   cin   in   carry in
//   sum   out  CHUNK-bit sum
//   cout  out  carry out of the slice MSB
//   ovf   out  signed overflow of this slice (meaningful on the top slice)
module alu_chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [CHUNK:0] full_sum;
    logic           msb_carry_in;

    assign full_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum      = full_sum[CHUNK-1:0];
    assign cout     = full_sum[CHUNK];

    // Carry into the MSB recovered from the MSB sum bit; overflow is when it
    // differs from the carry out of the MSB.
    assign msb_carry_in = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
    assign ovf          = msb_carry_in ^ cout;

endmodule

// File: rtl/alu_serial_responder.sv
// Handshaked multi-cycle ALU. One request (op, a, b) is accepted on the
// req_* valid/ready channel; the result, zero flag and illegal-op flag are
// returned on the resp_* valid/ready channel. Logic ops finish at the
// accepting edge; ADD/SUB/SLT ripple through W/CHUNK slices of a single
// CHUNK-bit adder, one slice per edge, LSB slice first.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_op, req_a, req_b          operation and operands
//   resp_valid/resp_ready         response handshake
//   resp_z, resp_zero, resp_err   result, result==0, illegal-op flag
module alu_serial_responder
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_z,
    output logic         resp_zero,
    output logic         resp_err
);

    localparam int NCH = W / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NCH - 1);

    logic [1:0]    state_reg;
    logic [2:0]    op_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  z_reg;
    logic          zero_reg;
    logic          err_reg;
    logic [CW-1:0] cnt_reg;
    logic          carry_reg;

    logic             idle;
    logic [2:0]       cur_op;
    logic [W-1:0]     cur_a;
    logic [W-1:0]     b_eff;
    logic [W-1:0]     base_z;
    logic [W-1:0]     merged_z;
    logic [W-1:0]     arith_z;
    logic [W-1:0]     logic_z;
    logic [CW-1:0]    idx;
    logic             last_slice;
    logic [CHUNK-1:0] a_sl [NCH];
    logic [CHUNK-1:0] b_sl [NCH];
    logic [CHUNK-1:0] add_a;
    logic [CHUNK-1:0] add_b;
    logic             add_cin;
    logic [CHUNK-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    assign idle = (state_reg == ST_IDLE);

    // Slice 0 is computed straight from the request at the accepting edge,
    // so an N-slice operation presents its response N cycles after accept,
    // the same way a logic op presents it one cycle after accept.
    assign cur_op = idle ? req_op : op_reg;
    assign cur_a  = idle ? req_a  : a_reg;
    assign b_eff  = is_subtract(cur_op) ? ~(idle ? req_b : b_reg)
                                        :  (idle ? req_b : b_reg);
    assign idx    = idle ? '0 : cnt_reg;
    assign base_z = idle ? '0 : z_reg;

    assign last_slice = (idx == LAST_SLICE);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
            assign a_sl[gi] = cur_a[gi*CHUNK +: CHUNK];
            assign b_sl[gi] = b_eff[gi*CHUNK +: CHUNK];
            // Partial result with the current slice's sum dropped in place.
            assign merged_z[gi*CHUNK +: CHUNK] =
                (idx == CW'(gi)) ? add_sum : base_z[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign add_a   = a_sl[idx];
    assign add_b   = b_sl[idx];
    assign add_cin = idle ? is_subtract(cur_op) : carry_reg;

    alu_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // SLT only makes sense once the top slice has been added; earlier
    // slices still write the partial difference, which is overwritten here.
    assign arith_z = (cur_op == OP_SLT)
                   ? {{(W-1){1'b0}}, add_sum[CHUNK-1] ^ add_ovf}
                   : merged_z;

    assign logic_z = (req_op == OP_AND) ? (req_a & req_b) : (req_a | req_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_AND;
            a_reg     <= '0;
            b_reg     <= '0;
            z_reg     <= '0;
            zero_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg  <= req_op;
                        a_reg   <= req_a;
                        b_reg   <= req_b;
                        err_reg <= 1'b0;
                        if (is_arith(req_op)) begin
                            carry_reg <= add_cout;
                            if (last_slice) begin
                                z_reg     <= arith_z;
                                zero_reg  <= (arith_z == '0);
                                cnt_reg   <= '0;
                                state_reg <= ST_RESP;
                            end else begin
                                z_reg     <= merged_z;
                                zero_reg  <= 1'b0;
                                cnt_reg   <= CW'(1);
                                state_reg <= ST_CALC;
                            end
                        end else if (req_op == OP_AND || req_op == OP_OR) begin
                            z_reg     <= logic_z;
                            zero_reg  <= (logic_z == '0);
                            state_reg <= ST_RESP;
                        end else begin
                            z_reg     <= '0;
                            zero_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_CALC: begin
                    carry_reg <= add_cout;
                    if (last_slice) begin
                        z_reg     <= arith_z;
                        zero_reg  <= (arith_z == '0);
                        cnt_reg   <= '0;
                        state_reg <= ST_RESP;
                    end else begin
                        z_reg   <= merged_z;
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = idle;
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_z     = z_reg;
    assign resp_zero  = zero_reg;
    assign resp_err   = err_reg;

endmodule

// File: tb/tb_alu_serial_responder.sv
module tb_alu_serial_responder;

    localparam int W = 32;
    localparam int CHUNK = 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_z;
    logic          resp_zero;
    logic          resp_err;

    int n_total;
    int n_pass;

    alu_serial_responder #(
        .W     (W),
        .CHUNK (CHUNK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  z;
        logic         zero;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Wait (bounded) until the block is ready, present one request, and
    // measure cycles from the accepting edge until resp_valid.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("resp_valid_drops", {31'd0, resp_valid}, 32'd0);
        check("req_ready_returns", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.op, v.a, v.b, lat);
        check({v.name, "_lat"},  lat, v.lat);
        check({v.name, "_z"},    resp_z, v.z);
        check({v.name, "_zero"}, {31'd0, resp_zero}, {31'd0, v.zero});
        check({v.name, "_err"},  {31'd0, resp_err}, {31'd0, v.err});
        $display("txn %s op=%b a=%08h b=%08h -> z=%08h zero=%0b err=%0b lat=%0d",
                 v.name, v.op, v.a, v.b, resp_z, resp_zero, resp_err, lat);
        consume();
    endtask

    initial begin
        int lat;
        logic [31:0] held_z;
        n_total = 0;
        n_pass  = 0;

        vecs[0]  = '{"and_pat",   3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1};
        vecs[1]  = '{"and_zero",  3'b000, 32'hAAAA5555, 32'h5555AAAA, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[2]  = '{"or_pat",    3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1};
        vecs[3]  = '{"add_ripple",3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 4};
        vecs[4]  = '{"add_wrap",  3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4};
        vecs[5]  = '{"sub_eq",    3'b110, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 4};
        vecs[6]  = '{"sub_neg",   3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 4};
        vecs[7]  = '{"slt_m1_1",  3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 4};
        vecs[8]  = '{"slt_ovf",   3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 4};
        vecs[9]  = '{"slt_min",   3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4};
        vecs[10] = '{"slt_eq",    3'b111, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 4};
        vecs[11] = '{"illegal100",3'b100, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'b000;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_z",     resp_z, 32'd0);
        check("rst_resp_zero",  {31'd0, resp_zero}, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Back-pressure: response held while resp_ready stays low, and a
        // request offered meanwhile must not be taken.
        issue(3'b010, 32'h00000001, 32'h00000002, lat);
        check("bp_lat", lat, 4);
        held_z = 32'h00000003;
        req_valid = 1'b1;
        req_op    = 3'b011;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_req_ready",  {31'd0, req_ready}, 32'd0);
            check("bp_resp_z",     resp_z, held_z);
            check("bp_resp_err",   {31'd0, resp_err}, 32'd0);
            $display("txn bp_hold cycle=%0d z=%08h valid=%0b ready=%0b", c, resp_z, resp_valid, req_ready);
        end
        req_valid = 1'b0;
        consume();
        run_vec('{"illegal011", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1});

        // Reset in the middle of CALC (slice 2), then a clean ADD.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b010;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_calc_busy", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_req_ready",  {31'd0, req_ready}, 32'd1);
        check("abort_resp_z",     resp_z, 32'd0);
        $display("txn reset_mid_calc valid=%0b ready=%0b z=%08h", resp_valid, req_ready, resp_z);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        run_vec('{"add_after_rst", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 4});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
